// File: rtl/fetch.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, in-order
// instruction queue towards decode. Optional macro: FETCH_MISALIGN_CHECK_EN.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_encoding,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [31:0]   mem_word_q [DEPTH];
    logic [31:0]   mem_pc_q   [DEPTH];

    logic          halt;
    logic          req_fire, rsp_fire, push, pop;
    logic [CW:0]   credit_used;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d;
    assign halt        = fault_q;
    assign fetch_fault = fault_q;
`else
    assign halt = 1'b0;
`endif

    assign credit_used    = {1'b0, count_q} + {1'b0, outst_q};
    assign imem_req_valid = !rst && !halt && (credit_used < DEPTH_W);
    assign imem_addr      = pc_q;
    assign inst_valid     = (count_q != '0);
    assign inst_encoding  = inst_valid ? mem_word_q[head_q] : 32'h0;
    assign inst_pc        = inst_valid ? mem_pc_q[head_q]   : 32'h0;

    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        drop_d   = drop_q;
        push     = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_d  = fault_q;
`endif
        req_fire = imem_req_valid && imem_req_ready;
        rsp_fire = imem_rsp_valid && (outst_q != '0);
        pop      = inst_valid && inst_ready;
        outst_d  = outst_q + CW'(req_fire) - CW'(rsp_fire);

        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old stream.
            pc_d     = redirect_pc & ~32'h3;
            rsp_pc_d = redirect_pc & ~32'h3;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            drop_d   = outst_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) fault_d = 1'b1;
`endif
        end else begin
            if (req_fire) pc_d = pc_q + 32'd4;
            if (rsp_fire) begin
                if (drop_q != '0) drop_d = drop_q - CW'(1);
                else              push   = 1'b1;
            end
            if (push) begin
                tail_d   = tail_q + AW'(1);
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (pop) head_d = head_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q  <= fault_d;
`endif
        end
    end

    // NOTE: queue storage is not reset; count gates the outputs, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_word_q[tail_q] <= imem_rsp_data;
            mem_pc_q[tail_q]   <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: vector table for streaming/stall, hand sequences for
// redirect, reset, wrap and misaligned-target corner cases.
module tb_fetch;

    localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_encoding;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_encoding  (inst_encoding),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        ready;
        logic        spur;
        logic        iv;
        logic [31:0] ipc;
        logic        rv;
        logic [31:0] addr;
    } vec_t;

    int    total;
    int    bad;
    int    cyc;
    int    lat;
    logic  spur;
    mreq_t mq[$];
    vec_t  vec[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic iv,
                                input logic [31:0] ipc, input logic rv, input logic [31:0] addr);
        vec_t v;
        v.ready = r; v.spur = s; v.iv = iv; v.ipc = ipc; v.rv = rv; v.addr = addr;
        return v;
    endfunction

    // Memory model: drive this cycle's response, then log any request accepted this cycle.
    task automatic eval_cycle();
        mreq_t m;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].addr ^ XOR_KEY;
            mq.delete(0);
        end else if (spur) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        #1;
        if (rst) begin
            mq.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            m.addr = imem_addr;
            m.due  = cyc + lat;
            mq.push_back(m);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input logic redir, input logic [31:0] rpc);
        rst            = 1'b1;
        redirect_valid = redir;
        redirect_pc    = rpc;
        eval_cycle();
        check("rst req_valid", {31'h0, imem_req_valid}, 32'h0);
        next_cycle();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        cyc            = 0;
    endtask

    task automatic expect_stream(input string name, input logic [31:0] first, input int n);
        int          got;
        int          budget;
        logic [31:0] exp_pc;
        got    = 0;
        budget = 40;
        inst_ready = 1'b1;
        while (got < n && budget > 0) begin
            eval_cycle();
            if (inst_valid) begin
                exp_pc = first + 32'(4 * got);
                check($sformatf("%s pc[%0d]", name, got), inst_pc, exp_pc);
                check($sformatf("%s word[%0d]", name, got), inst_encoding, exp_pc ^ XOR_KEY);
                got++;
            end
            next_cycle();
            budget--;
        end
        if (got < n) check($sformatf("%s timeout delivered", name), 32'(got), 32'(n));
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        cyc            = 0;
        lat            = 1;
        spur           = 1'b0;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        //           rdy  spur iv  inst_pc       rv  imem_addr
        vec[0]  = mk(1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00);
        vec[1]  = mk(1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h04);
        vec[2]  = mk(1'b1, 1'b0, 1'b1, 32'h00, 1'b1, 32'h08);
        vec[3]  = mk(1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 32'h0C);
        vec[4]  = mk(1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h10);
        vec[5]  = mk(1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h14);
        vec[6]  = mk(1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h18);
        vec[7]  = mk(1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h1C);
        vec[8]  = mk(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h20);
        vec[9]  = mk(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h20);
        vec[10] = mk(1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h20);
        vec[11] = mk(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h20);
        vec[12] = mk(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h20);
        vec[13] = mk(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h20);
        vec[14] = mk(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h20);
        vec[15] = mk(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h20);
        vec[16] = mk(1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h20);
        vec[17] = mk(1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h20);
        vec[18] = mk(1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h24);
        vec[19] = mk(1'b1, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h28);
        vec[20] = mk(1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h2C);
        vec[21] = mk(1'b1, 1'b0, 1'b1, 32'h24, 1'b1, 32'h30);

        @(negedge clk);
        do_reset(1'b0, 32'h0);

        // Stream from reset, stall for ten cycles with a spurious response, then release.
        for (int i = 0; i < 22; i++) begin
            inst_ready = vec[i].ready;
            spur       = vec[i].spur;
            eval_cycle();
            check($sformatf("v%0d inst_valid", i), {31'h0, inst_valid}, {31'h0, vec[i].iv});
            check($sformatf("v%0d req_valid", i), {31'h0, imem_req_valid}, {31'h0, vec[i].rv});
            check($sformatf("v%0d imem_addr", i), imem_addr, vec[i].addr);
            if (vec[i].iv || i < 2) begin
                check($sformatf("v%0d inst_pc", i), inst_pc, vec[i].iv ? vec[i].ipc : 32'h0);
                check($sformatf("v%0d inst_enc", i), inst_encoding,
                      vec[i].iv ? (vec[i].ipc ^ XOR_KEY) : 32'h0);
            end
            next_cycle();
        end
        spur = 1'b0;

        // Redirect coinciding with a response and a pop.
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        eval_cycle();
        check("b pre inst_valid", {31'h0, inst_valid}, 32'h1);
        next_cycle();
        redirect_valid = 1'b0;
        eval_cycle();
        check("b inst_valid", {31'h0, inst_valid}, 32'h0);
        check("b req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("b imem_addr", imem_addr, 32'h0000_0040);
        next_cycle();
        expect_stream("b", 32'h0000_0040, 3);

        // Reset mid-operation wins over a simultaneous redirect.
        lat = 3;
        do_reset(1'b1, 32'h0000_0500);
        eval_cycle();
        check("e inst_valid", {31'h0, inst_valid}, 32'h0);
        check("e inst_pc", inst_pc, 32'h0);
        check("e inst_enc", inst_encoding, 32'h0);
        check("e req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("e imem_addr", imem_addr, 32'h0);
        next_cycle();

        // Three-cycle memory: redirect with two requests in flight.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        eval_cycle();
        check("a pre imem_addr", imem_addr, 32'h0000_0004);
        next_cycle();
        redirect_valid = 1'b0;
        eval_cycle();
        check("a inst_valid", {31'h0, inst_valid}, 32'h0);
        check("a imem_addr", imem_addr, 32'h0000_0100);
        next_cycle();
        expect_stream("a", 32'h0000_0100, 3);

        // Back-to-back redirects: only the second stream survives.
        lat            = 2;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        eval_cycle();
        next_cycle();
        redirect_pc    = 32'h0000_0300;
        eval_cycle();
        next_cycle();
        redirect_valid = 1'b0;
        expect_stream("c", 32'h0000_0300, 4);

        // PC wraps past the top of the address space.
        lat            = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        eval_cycle();
        next_cycle();
        redirect_valid = 1'b0;
        expect_stream("f", 32'hFFFF_FFF8, 4);

        // Misaligned redirect target.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        eval_cycle();
        next_cycle();
        redirect_valid = 1'b0;
        eval_cycle();
`ifdef FETCH_MISALIGN_CHECK_EN
        check("d fetch_fault", {31'h0, fetch_fault}, 32'h1);
        check("d req_valid", {31'h0, imem_req_valid}, 32'h0);
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            eval_cycle();
            check($sformatf("d idle req_valid[%0d]", k), {31'h0, imem_req_valid}, 32'h0);
            check($sformatf("d idle inst_valid[%0d]", k), {31'h0, inst_valid}, 32'h0);
            next_cycle();
        end
`else
        check("d req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("d imem_addr", imem_addr, 32'h0000_0100);
        next_cycle();
        expect_stream("d", 32'h0000_0100, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
